// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, one write port and a per-register busy
// scoreboard so decode can spot read-after-write hazards on results still in flight.
module regfile_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  output logic [ADDR_W:0]          o_busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;

  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic [DEPTH-1:0]  w_wr_dec;
  logic [DEPTH-1:0]  w_rsv_dec;
  logic [DEPTH-1:0]  w_busy_next;
  logic [ADDR_W:0]   w_busy_cnt_next;

  // Writes and reservations aimed at a hardwired-zero r0 are simply dropped.
  assign w_wr_ok  = i_wr_en  && !(ZERO_R0 && (i_wr_addr  == '0));
  assign w_rsv_ok = i_rsv_en && !(ZERO_R0 && (i_rsv_addr == '0));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign w_wr_dec[gi]    = w_wr_ok  && (i_wr_addr  == ADDR_W'(gi));
      assign w_rsv_dec[gi]   = w_rsv_ok && (i_rsv_addr == ADDR_W'(gi));
      // A new producer issued in the same cycle as the old one retires keeps the entry busy.
      assign w_busy_next[gi] = w_rsv_dec[gi] | (r_busy[gi] & ~w_wr_dec[gi]);
    end
  endgenerate

  always_comb begin
    w_busy_cnt_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_busy_cnt_next = w_busy_cnt_next + {{ADDR_W{1'b0}}, w_busy_next[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_busy_cnt_next;
    end
  end

  assign o_busy_cnt = r_busy_cnt;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_is_r0;
      logic              w_byp_hit;

      assign w_addr    = i_rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_is_r0   = ZERO_R0 && (w_addr == '0);
      assign w_byp_hit = BYPASS && w_wr_ok && (i_wr_addr == w_addr);

      assign o_rd_data[gi*DATA_W +: DATA_W] = w_is_r0   ? '0        :
                                              w_byp_hit ? i_wr_data :
                                                          r_regs[w_addr];
      // Forwarded data is final, so the consumer sees the register as ready.
      assign o_rd_busy[gi] = !w_is_r0 && r_busy[w_addr] && !w_byp_hit;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised bench: the driver pushes expected outputs from an array-based model,
// and a negedge monitor pops and compares them against the DUT.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  i_rd_addr;
  logic [63:0] o_rd_data;
  logic [1:0]  o_rd_busy;
  logic        i_wr_en;
  logic [4:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_rsv_en;
  logic [4:0]  i_rsv_addr;
  logic [5:0]  o_busy_cnt;

  regfile_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_addr  (i_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_rd_busy  (o_rd_busy),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_rsv_en   (i_rsv_en),
    .i_rsv_addr (i_rsv_addr),
    .o_busy_cnt (o_busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  bz;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Reference state: architectural register values and the set of in-flight destinations.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic logic [5:0] model_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return 6'(c);
  endfunction

  function automatic logic [31:0] model_rd(bit we, logic [4:0] wa, logic [31:0] wd, logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic bit model_bz(bit we, logic [4:0] wa, logic [4:0] a);
    if (a == 0) return 1'b0;
    if (we && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input bit re, input logic [4:0] ra,
                      input logic [4:0] a0, input logic [4:0] a1, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    i_wr_en    = we;
    i_wr_addr  = wa;
    i_wr_data  = wd;
    i_rsv_en   = re;
    i_rsv_addr = ra;
    i_rd_addr  = {a1, a0};
    e.tag = tag;
    e.a0  = a0;
    e.a1  = a1;
    e.d0  = model_rd(we, wa, wd, a0);
    e.d1  = model_rd(we, wa, wd, a1);
    e.bz  = {model_bz(we, wa, a1), model_bz(we, wa, a0)};
    e.cnt = model_cnt();
    sb_q.push_back(e);
    // Edge effects: the writeback retires its producer, then a reservation (if any) re-arms it.
    if (we && wa != 0) begin
      m_mem[wa]  = wd;
      m_busy[wa] = 1'b0;
    end
    if (re && ra != 0) m_busy[ra] = 1'b1;
  endtask

  // Reset pulse placed wholly between two rising edges.
  task automatic reset_mid(input logic [4:0] a0, input logic [4:0] a1);
    exp_t e;
    @(posedge clk);
    #1;
    i_wr_en   = 1'b0;
    i_rsv_en  = 1'b0;
    i_rd_addr = {a1, a0};
    rst_n     = 1'b0;
    model_clear();
    e.tag = "rst_mid";
    e.a0  = a0;
    e.a1  = a1;
    e.d0  = '0;
    e.d1  = '0;
    e.bz  = '0;
    e.cnt = '0;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      $display("[%s] a0=%0d a1=%0d d0=%h d1=%h busy=%b cnt=%0d", e.tag, e.a0, e.a1,
               o_rd_data[31:0], o_rd_data[63:32], o_rd_busy, o_busy_cnt);
      chk({e.tag, " rd_data0"}, o_rd_data[31:0],  e.d0);
      chk({e.tag, " rd_data1"}, o_rd_data[63:32], e.d1);
      chk({e.tag, " rd_busy"},  32'(o_rd_busy),   32'(e.bz));
      chk({e.tag, " busy_cnt"}, 32'(o_busy_cnt),  32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  wa, ra, a0, a1;
    logic [31:0] wd;
    bit          we, re;

    rst_n      = 1'b0;
    i_wr_en    = 1'b0;
    i_wr_addr  = '0;
    i_wr_data  = '0;
    i_rsv_en   = 1'b0;
    i_rsv_addr = '0;
    i_rd_addr  = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 5'(i), 5'(i), "reset_sweep");

    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, "wr_r5_bypass");
    step(0, 0, 0, 0, 0, 5, 5, "rd_r5");

    step(1, 0, 32'h12345678, 0, 0, 0, 0, "wr_r0");
    step(0, 0, 0, 1, 0, 0, 0, "rsv_r0");
    step(0, 0, 0, 0, 0, 0, 0, "rd_r0");

    step(0, 0, 0, 1, 7, 7, 9, "rsv_r7");
    step(0, 0, 0, 1, 9, 7, 9, "rsv_r9");
    step(0, 0, 0, 0, 0, 7, 9, "rd_r7_r9");
    step(1, 7, 32'hA5, 0, 0, 7, 9, "wr_r7");
    step(0, 0, 0, 0, 0, 7, 9, "after_wr_r7");

    step(0, 0, 0, 1, 3, 3, 3, "rsv_r3");
    step(1, 3, 32'h55, 1, 3, 3, 3, "wr_rsv_r3");
    step(0, 0, 0, 0, 0, 3, 3, "after_wr_rsv_r3");

    step(1, 10, 32'h1111_0001, 1, 20, 10, 20, "load0");
    step(1, 11, 32'h2222_0002, 1, 21, 11, 21, "load1");
    step(1, 12, 32'h3333_0003, 1, 22, 12, 22, "load2");
    step(1, 13, 32'h4444_0004, 0, 0, 13, 10, "load3");
    step(0, 0, 0, 0, 0, 10, 21, "pre_rst");
    reset_mid(10, 21);
    step(0, 0, 0, 0, 0, 12, 22, "post_rst");
    step(1, 12, 32'hCAFE_F00D, 0, 0, 12, 3, "post_rst_wr");
    step(0, 0, 0, 0, 0, 12, 12, "post_rst_rd");

    for (int i = 0; i < 360; i++) begin
      we = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 2) == 0);
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wd = $urandom;
      a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      if (i % 120 == 119) reset_mid(a0, a1);
      else step(we, wa, wd, re, ra, a0, a1, "rand");
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected responses never checked, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
